axis_packet_merger: RTL and testbench
=====================================

// Module: axis_packet_merger
// PURPOSE
//  Reassembly counterpart of the packet splitter. Accepts pckt_count input packets of pckt_size beats each
//  and emits one output packet of pckt_size*pckt_count beats. Intermediate tlast is stripped; size
//  violations are flagged. Output passes through a skid-buffer AXI-Stream register.
// PARAMETERS
//  DATA_WIDTH           16                  tdata width (bits)
//  KEEP_ENABLE/WIDTH    (DATA_WIDTH>8)/(DATA_WIDTH+7)/8   tkeep propagate / width
//  ID/DEST/USER_ENABLE  0/0/0               propagate tid/tdest/tuser
//  ID/DEST/USER_WIDTH   8/8/8 if enabled else 1           sideband widths
//  PCKT_WIDTH           32                  width of pckt_size and beat counter
//  CNT_WIDTH            16                  width of pckt_count and packet counter
//  ALLOW_LOCKS          1                   lock input honoured when 1
//  RAISE_SIZE_MISMATCH  1                   1: size violation -> ERR; 0: violation ignored, tlast forwarded
// PORTS
//  clk                  in   1        clock
//  rst                  in   1        reset, synchronous, active-high
//  operation_start      in   1        start request; sampled in IDLE/END
//  pckt_size            in   PCKT     beats per input packet; latched on start
//  pckt_count           in   CNT      input packets per output packet; latched on start
//  lock                 in   1        freeze FSM and stall input
//  external_error       in   1        force ERR
//  operation_busy       out  1        registered; high while in OPE
//  operation_complete   out  1        registered; 1-cycle pulse in END
//  operation_error      out  1        registered; 1-cycle pulse in ERR
//  transmission         out  1        registered m_axis_tvalid&&m_axis_tready
//  s_axis_tdata/tkeep   in   DATA/KEEP  input data, keep
//  s_axis_tvalid/tlast  in   1/1      input valid, last
//  s_axis_tready        out  1        busy && !lock && skid-buffer ready
//  s_axis_tid/tdest/tuser in ID/DEST/USER  input sideband, forwarded unchanged
//  m_axis_tdata/tkeep   out  DATA/KEEP  output data, keep
//  m_axis_tvalid/tlast  out  1/1      output valid, merged last
//  m_axis_tready        in   1        output ready
//  m_axis_tid/tdest/tuser out ID/DEST/USER output sideband
// BEHAVIOUR
//  - Reset: FSM=IDLE, counters=0, all status outputs 0, m_axis_tvalid=0, s_axis_tready=0.
//  - FSM IDLE(0) OPE(1) ERR(2) END(3). Status outputs decode next state, so they are valid in that state's cycle.
//  - IDLE/END: start=1 -> latch sizes, clear beat_cnt/pkt_cnt -> OPE (back-to-back from END allowed); else IDLE.
//    If pckt_size==0 or pckt_count==0 at start -> ERR.
//  - OPE: accepted beat = s_axis_tvalid&&s_axis_tready. last_beat = (beat_cnt==pckt_size-1); last_pkt = (pkt_cnt==pckt_count-1).
//    No tlast, !last_beat -> beat_cnt++, m_tlast=0.
//    tlast && last_beat && !last_pkt -> beat_cnt=0, pkt_cnt++, m_tlast=0 (stripped).
//    tlast && last_beat && last_pkt -> m_tlast=1, -> END.
//    Mismatch: tlast && !last_beat (early), or !tlast && last_beat (missing).
//    RAISE_SIZE_MISMATCH=1: beat forwarded with m_tlast forced 1, -> ERR.
//    RAISE_SIZE_MISMATCH=0, early: counts restart at packet boundary as for a normal end.
//    RAISE_SIZE_MISMATCH=0, missing: beat_cnt wraps to 0, m_tlast=0.
//  - ERR: single cycle, then IDLE. END: single cycle.
//  - Priority, high to low: rst > external_error (-> ERR from any state) > lock (ALLOW_LOCKS=1: state and
//    counters hold, s_axis_tready=0) > normal transitions.
//  - Latency: 1 cycle from accepted input beat to m_axis_tvalid. Full skid buffer: no bubble at
//    m_axis_tready=1. Beats already in the buffer drain after END/ERR.
//  - Counters are unsigned, compared against latched size-1. No wrap within a legal operation.
// TESTING
//  1. pckt_size=4, pckt_count=3; 3 packets of 4 beats, tready=1 -> 12 output beats, m_tlast only on beat 12;
//     complete pulses once; busy high throughout.
//  2. Same config, m_axis_tready toggling 1/0 -> data order intact, no loss or duplication, one tlast.
//  3. pckt_size=4; tlast on beat 3 of packet 1 -> beat 3 out with m_tlast=1; error pulse; FSM back to IDLE.
//  4. pckt_size=4, no tlast on beat 4; RAISE_SIZE_MISMATCH=0 -> beat 4 forwarded, no error.
//  5. lock held 5 cycles mid-packet -> s_axis_tready=0, counts frozen; resumes correctly.
//     external_error mid-packet -> error pulse, then IDLE.
//  6. rst asserted mid-packet -> all outputs 0 next cycle.
//     pckt_count=0 at start -> error pulse.

Source files
------------

// File: rtl/axis_packet_merger.sv
// Merges pckt_count input packets of pckt_size beats into one output packet.
// Intermediate tlast is stripped; size violations are flagged or tolerated depending on
// RAISE_SIZE_MISMATCH. The output goes through a two-entry skid buffer.
module axis_packet_merger #(
  parameter int unsigned DATA_WIDTH          = 16,
  parameter bit          KEEP_ENABLE         = (DATA_WIDTH > 8),
  parameter int unsigned KEEP_WIDTH          = (DATA_WIDTH + 7) / 8,
  parameter bit          ID_ENABLE           = 1'b0,
  parameter bit          DEST_ENABLE         = 1'b0,
  parameter bit          USER_ENABLE         = 1'b0,
  parameter int unsigned ID_WIDTH            = ID_ENABLE ? 8 : 1,
  parameter int unsigned DEST_WIDTH          = DEST_ENABLE ? 8 : 1,
  parameter int unsigned USER_WIDTH          = USER_ENABLE ? 8 : 1,
  parameter int unsigned PCKT_WIDTH          = 32,
  parameter int unsigned CNT_WIDTH           = 16,
  parameter bit          ALLOW_LOCKS         = 1'b1,
  parameter bit          RAISE_SIZE_MISMATCH = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  operation_start,
  input  logic [PCKT_WIDTH-1:0] pckt_size,
  input  logic [CNT_WIDTH-1:0]  pckt_count,
  input  logic                  lock,
  input  logic                  external_error,
  output logic                  operation_busy,
  output logic                  operation_complete,
  output logic                  operation_error,
  output logic                  transmission,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser
);

  localparam int unsigned PayloadWidth =
      DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOpe  = 2'd1,
    StErr  = 2'd2,
    StEnd  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [PCKT_WIDTH-1:0]   size_q, size_d, beat_q, beat_d;
  logic [CNT_WIDTH-1:0]    count_q, count_d, pkt_q, pkt_d;
  logic                    busy_q, complete_q, error_q, transmission_q;
  logic                    m_valid_q, m_valid_d, skid_valid_q, skid_valid_d;
  logic [PayloadWidth-1:0] m_data_q, m_data_d, skid_data_q, skid_data_d, in_payload;

  logic                  lock_eff, s_fire, last_beat, last_pkt, mismatch, in_last;
  logic [KEEP_WIDTH-1:0] keep_in;
  logic [ID_WIDTH-1:0]   id_in;
  logic [DEST_WIDTH-1:0] dest_in;
  logic [USER_WIDTH-1:0] user_in;

  assign lock_eff      = ALLOW_LOCKS ? lock : 1'b0;
  // Skid buffer can take a beat whenever its second slot is empty.
  assign s_axis_tready = (state_q == StOpe) && !lock_eff && !skid_valid_q;
  assign s_fire        = s_axis_tvalid && s_axis_tready;
  assign last_beat     = (beat_q == size_q - PCKT_WIDTH'(1));
  assign last_pkt      = (pkt_q == count_q - CNT_WIDTH'(1));
  assign mismatch      = s_axis_tlast ^ last_beat;
  // Early tlast ends the merged packet only on the last input packet when tolerated.
  assign in_last       = s_axis_tlast ? (last_pkt || (RAISE_SIZE_MISMATCH && !last_beat))
                                      : (RAISE_SIZE_MISMATCH && last_beat);

  assign keep_in    = KEEP_ENABLE ? s_axis_tkeep : {KEEP_WIDTH{1'b1}};
  assign id_in      = ID_ENABLE ? s_axis_tid : '0;
  assign dest_in    = DEST_ENABLE ? s_axis_tdest : '0;
  assign user_in    = USER_ENABLE ? s_axis_tuser : '0;
  assign in_payload = {s_axis_tdata, keep_in, in_last, id_in, dest_in, user_in};

  // Next state and counters: external_error beats lock, lock beats normal flow.
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    count_d = count_q;
    beat_d  = beat_q;
    pkt_d   = pkt_q;
    if (external_error) begin
      state_d = StErr;
    end else if (!lock_eff) begin
      unique case (state_q)
        StIdle, StEnd: begin
          state_d = StIdle;
          if (operation_start) begin
            size_d  = pckt_size;
            count_d = pckt_count;
            beat_d  = '0;
            pkt_d   = '0;
            state_d = (pckt_size == '0 || pckt_count == '0) ? StErr : StOpe;
          end
        end
        StOpe: begin
          if (s_fire) begin
            if (mismatch && RAISE_SIZE_MISMATCH) begin
              state_d = StErr;
            end else if (s_axis_tlast) begin
              if (last_pkt) begin
                state_d = StEnd;
              end else begin
                beat_d = '0;
                pkt_d  = pkt_q + CNT_WIDTH'(1);
              end
            end else if (last_beat) begin
              beat_d = '0;
            end else begin
              beat_d = beat_q + PCKT_WIDTH'(1);
            end
          end
        end
        StErr: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Two-entry skid buffer: output register plus one overflow slot.
  always_comb begin
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!m_valid_q || m_axis_tready) begin
      if (skid_valid_q) begin
        m_data_d     = skid_data_q;
        m_valid_d    = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        m_valid_d = s_fire;
        if (s_fire) m_data_d = in_payload;
      end
    end else if (s_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_payload;
    end
  end

  // State, counters, status flags and buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      size_q         <= '0;
      count_q        <= '0;
      beat_q         <= '0;
      pkt_q          <= '0;
      busy_q         <= 1'b0;
      complete_q     <= 1'b0;
      error_q        <= 1'b0;
      transmission_q <= 1'b0;
      m_valid_q      <= 1'b0;
      m_data_q       <= '0;
      skid_valid_q   <= 1'b0;
      skid_data_q    <= '0;
    end else begin
      state_q        <= state_d;
      size_q         <= size_d;
      count_q        <= count_d;
      beat_q         <= beat_d;
      pkt_q          <= pkt_d;
      busy_q         <= (state_d == StOpe);
      complete_q     <= (state_d == StEnd);
      error_q        <= (state_d == StErr);
      transmission_q <= m_valid_q && m_axis_tready;
      m_valid_q      <= m_valid_d;
      m_data_q       <= m_data_d;
      skid_valid_q   <= skid_valid_d;
      skid_data_q    <= skid_data_d;
    end
  end

  assign operation_busy     = busy_q;
  assign operation_complete = complete_q;
  assign operation_error    = error_q;
  assign transmission       = transmission_q;
  assign m_axis_tvalid      = m_valid_q;
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser} =
      m_data_q;

endmodule

// File: tb/tb_axis_packet_merger.sv
// Bench for axis_packet_merger: queue-based reference model checked every cycle, plus
// literal end-of-test expectations. A second instance exercises tolerated size mismatch.
module tb_axis_packet_merger;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, operation_start, lock, external_error;
  logic [31:0] pckt_size;
  logic [15:0] pckt_count;
  logic        operation_busy, operation_complete, operation_error, transmission;
  logic [15:0] s_tdata, m_tdata;
  logic [1:0]  s_tkeep, m_tkeep;
  logic        s_tvalid, s_tlast, s_tready, m_tvalid, m_tlast, m_tready;
  logic        s_tid, s_tdest, s_tuser, m_tid, m_tdest, m_tuser;

  axis_packet_merger #(.RAISE_SIZE_MISMATCH(1'b1)) dut (
    .clk(clk), .rst(rst), .operation_start(operation_start), .pckt_size(pckt_size),
    .pckt_count(pckt_count), .lock(lock), .external_error(external_error),
    .operation_busy(operation_busy), .operation_complete(operation_complete),
    .operation_error(operation_error), .transmission(transmission),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready), .s_axis_tid(s_tid),
    .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready), .m_axis_tid(m_tid), .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser)
  );

  // Tolerant instance, driven only during the missing-tlast test.
  logic        r0_start, r0_busy, r0_complete, r0_error, r0_trans;
  logic [15:0] r0_s_tdata, r0_m_tdata;
  logic [1:0]  r0_m_tkeep;
  logic        r0_s_tvalid, r0_s_tlast, r0_s_tready, r0_m_tvalid, r0_m_tlast;
  logic        r0_m_tid, r0_m_tdest, r0_m_tuser;

  axis_packet_merger #(.RAISE_SIZE_MISMATCH(1'b0)) dut0 (
    .clk(clk), .rst(rst), .operation_start(r0_start), .pckt_size(32'd4),
    .pckt_count(16'd1), .lock(1'b0), .external_error(1'b0),
    .operation_busy(r0_busy), .operation_complete(r0_complete),
    .operation_error(r0_error), .transmission(r0_trans),
    .s_axis_tdata(r0_s_tdata), .s_axis_tkeep(2'b11), .s_axis_tvalid(r0_s_tvalid),
    .s_axis_tlast(r0_s_tlast), .s_axis_tready(r0_s_tready), .s_axis_tid(1'b0),
    .s_axis_tdest(1'b0), .s_axis_tuser(1'b0), .m_axis_tdata(r0_m_tdata),
    .m_axis_tkeep(r0_m_tkeep), .m_axis_tvalid(r0_m_tvalid), .m_axis_tlast(r0_m_tlast),
    .m_axis_tready(1'b1), .m_axis_tid(r0_m_tid), .m_axis_tdest(r0_m_tdest),
    .m_axis_tuser(r0_m_tuser)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  k;
    logic        l;
  } beat_t;

  // Reference model: operation mode 0 idle, 1 running, 2 error, 3 end.
  beat_t       mq[$];
  int          st = 0;
  int unsigned m_size, m_count, m_beat, m_pkt;
  logic        exp_trans = 1'b0;
  bit          last_s_fire;
  int          ready_mode;
  int          checks = 0, errors = 0;
  int          n_out, n_last, last_pos, n_complete, n_error;

  logic [16:0] r0_out[$];
  int          r0_n_complete = 0, r0_n_error = 0;

  always @(negedge clk) begin
    if (r0_m_tvalid) r0_out.push_back({r0_m_tdata, r0_m_tlast});
    if (r0_complete) r0_n_complete++;
    if (r0_error) r0_n_error++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_counts();
    n_out = 0; n_last = 0; last_pos = 0; n_complete = 0; n_error = 0;
  endtask

  // One clock cycle: compare against the model, record, then advance the model.
  task automatic step();
    bit    exp_rdy, m_fire, s_fire, pos_last, pkt_last;
    beat_t b;
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
    @(negedge clk);
    exp_rdy = (st == 1) && !lock && (mq.size() < 2);
    chk("busy", operation_busy, st == 1);
    chk("complete", operation_complete, st == 3);
    chk("error", operation_error, st == 2);
    chk("transmission", transmission, exp_trans);
    chk("s_tready", s_tready, exp_rdy);
    chk("m_tvalid", m_tvalid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("m_tdata", m_tdata, mq[0].d);
      chk("m_tkeep", m_tkeep, mq[0].k);
      chk("m_tlast", m_tlast, mq[0].l);
    end
    if (m_tvalid && m_tready) begin
      n_out++;
      if (m_tlast) begin n_last++; last_pos = n_out; end
    end
    if (operation_complete) n_complete++;
    if (operation_error) n_error++;
    m_fire = (mq.size() > 0) && m_tready;
    s_fire = s_tvalid && exp_rdy;
    last_s_fire = s_fire;
    if (rst) begin
      st = 0; mq.delete(); exp_trans = 1'b0;
    end else begin
      exp_trans = m_fire;
      if (m_fire) void'(mq.pop_front());
      if (external_error) st = 2;
      else if (!lock) begin
        case (st)
          0, 3: begin
            st = 0;
            if (operation_start) begin
              if (pckt_size == 0 || pckt_count == 0) st = 2;
              else begin
                m_size = pckt_size; m_count = pckt_count; m_beat = 0; m_pkt = 0; st = 1;
              end
            end
          end
          2: st = 0;
          default: if (s_fire) begin
            pos_last = (m_beat == m_size - 1);
            pkt_last = (m_pkt == m_count - 1);
            b.d = s_tdata; b.k = s_tkeep; b.l = 1'b0;
            if (s_tlast != pos_last) begin
              b.l = 1'b1; st = 2;             // size violation is raised
            end else if (!s_tlast) m_beat++;
            else if (pkt_last) begin b.l = 1'b1; st = 3; end
            else begin m_beat = 0; m_pkt++; end
            mq.push_back(b);
          end
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input int unsigned size, input int unsigned count);
    pckt_size = size; pckt_count = 16'(count); operation_start = 1'b1;
    step();
    operation_start = 1'b0;
  endtask

  task automatic send(input logic last, input bit gaps);
    if (gaps && $urandom_range(0, 3) == 0) step();
    s_tvalid = 1'b1; s_tdata = 16'($urandom); s_tkeep = 2'($urandom); s_tlast = last;
    for (int i = 0; i < 64; i++) begin
      step();
      if (last_s_fire) break;
    end
    if (!last_s_fire) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=no_accept required=accept at %0t", $time);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send0(input logic [15:0] d, input logic last);
    bit ok = 0;
    r0_s_tvalid = 1'b1; r0_s_tdata = d; r0_s_tlast = last;
    for (int i = 0; i < 32 && !ok; i++) begin
      @(negedge clk);
      ok = r0_s_tready;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send0_timeout actual=no_accept required=accept at %0t", $time);
    end
    @(posedge clk); #1;
    r0_s_tvalid = 1'b0; r0_s_tlast = 1'b0;
  endtask

  initial begin
    int unsigned sz, ct, total;
    logic        any_last;
    rst = 1'b1; operation_start = 1'b0; lock = 1'b0; external_error = 1'b0;
    pckt_size = 0; pckt_count = 0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0;
    s_tid = 1'b0; s_tdest = 1'b0; s_tuser = 1'b0; m_tready = 1'b1; ready_mode = 0;
    r0_start = 1'b0; r0_s_tvalid = 1'b0; r0_s_tlast = 1'b0; r0_s_tdata = '0;
    @(posedge clk); #1;
    drain(2);
    chk("reset_busy", operation_busy, 0);
    chk("reset_s_tready", s_tready, 0);
    rst = 1'b0;
    drain(2);

    // 1: three packets of four beats, always ready.
    clear_counts();
    start_op(4, 3);
    for (int i = 0; i < 12; i++) send(i % 4 == 3, 1'b0);
    drain(4);
    chk("t1_beats", n_out, 12);
    chk("t1_lasts", n_last, 1);
    chk("t1_last_pos", last_pos, 12);
    chk("t1_complete", n_complete, 1);

    // 2: same with toggling output ready.
    clear_counts();
    ready_mode = 1;
    start_op(4, 3);
    for (int i = 0; i < 12; i++) send(i % 4 == 3, 1'b0);
    drain(8);
    chk("t2_beats", n_out, 12);
    chk("t2_last_pos", last_pos, 12);
    chk("t2_complete", n_complete, 1);

    // 3: early tlast on beat 3 of the first packet.
    clear_counts();
    ready_mode = 0;
    start_op(4, 3);
    send(1'b0, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0);
    drain(4);
    chk("t3_beats", n_out, 3);
    chk("t3_last_pos", last_pos, 3);
    chk("t3_error", n_error, 1);
    chk("t3_complete", n_complete, 0);

    // 4: missing tlast tolerated on the second instance.
    r0_start = 1'b1; @(posedge clk); #1; r0_start = 1'b0;
    for (int i = 0; i < 8; i++) send0(16'h1000 + 16'(i), i == 7);
    repeat (4) @(posedge clk);
    #1;
    chk("t4_beats", r0_out.size(), 8);
    any_last = 1'b0;
    for (int i = 0; i < 7 && i < r0_out.size(); i++) any_last |= r0_out[i][0];
    chk("t4_no_early_last", any_last, 0);
    if (r0_out.size() == 8) begin
      chk("t4_beat4", r0_out[3], {16'h1003, 1'b0});
      chk("t4_beat8", r0_out[7], {16'h1007, 1'b1});
    end
    chk("t4_error", r0_n_error, 0);
    chk("t4_complete", r0_n_complete, 1);

    // 5a: lock held five cycles mid-packet.
    clear_counts();
    start_op(4, 3);
    send(1'b0, 1'b0); send(1'b0, 1'b0);
    lock = 1'b1; s_tvalid = 1'b1; s_tdata = 16'hdead; s_tkeep = 2'b01;
    drain(5);
    lock = 1'b0; s_tvalid = 1'b0;
    for (int i = 2; i < 12; i++) send(i % 4 == 3, 1'b0);
    drain(4);
    chk("t5_beats", n_out, 12);
    chk("t5_last_pos", last_pos, 12);
    chk("t5_complete", n_complete, 1);

    // 5b: external error mid-packet.
    clear_counts();
    start_op(4, 3);
    for (int i = 0; i < 5; i++) send(i % 4 == 3, 1'b0);
    external_error = 1'b1; step(); external_error = 1'b0;
    drain(4);
    chk("t5_ext_error", n_error, 1);
    chk("t5_ext_beats", n_out, 5);

    // 6a: reset mid-packet.
    ready_mode = 2;
    start_op(4, 2);
    for (int i = 0; i < 3; i++) send(1'b0, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_rst_m_tvalid", m_tvalid, 0);
    chk("t6_rst_busy", operation_busy, 0);
    chk("t6_rst_transmission", transmission, 0);
    drain(3);

    // 6b: zero packet count at start.
    clear_counts();
    start_op(4, 0);
    drain(2);
    chk("t6_zero_count_error", n_error, 1);
    chk("t6_zero_count_complete", n_complete, 0);

    // Random operations, started back to back.
    clear_counts();
    total = 0;
    for (int op = 0; op < 8; op++) begin
      sz = $urandom_range(1, 5); ct = $urandom_range(1, 3);
      total += sz * ct;
      start_op(sz, ct);
      for (int i = 0; i < int'(sz * ct); i++) send(i % int'(sz) == int'(sz) - 1, 1'b1);
    end
    drain(12);
    chk("rand_beats", n_out, total);
    chk("rand_lasts", n_last, 8);
    chk("rand_complete", n_complete, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
